// File: rtl/stash_path_unpacker_pkg.sv
// Shared ORAM path-stream definitions: FSM encoding and bucket header field offsets,
// common to the path unpacker and the writeback packer.
package stash_path_unpacker_pkg;

  localparam int ORAML_DEF      = 32;
  localparam int ORAMU_DEF      = 32;
  localparam int ORAMZ_DEF      = 4;
  localparam int DATA_WIDTH_DEF = 512;
  localparam int BLK_CHUNKS_DEF = 2;

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_DATA   = 2'd1,
    ST_DONE   = 2'd2
  } unpack_state_e;

  // Header layout, LSB first: Z valid bits, then Z PAddrs, then Z leaves.
  function automatic int hdr_paddr_lsb(input int z, input int u, input int slot);
    return z + slot * u;
  endfunction

  function automatic int hdr_leaf_lsb(input int z, input int u, input int l, input int slot);
    return z + z * u + slot * l;
  endfunction

  function automatic int hdr_bits(input int z, input int u, input int l);
    return z * (1 + u + l);
  endfunction

endpackage

// File: rtl/stash_path_unpacker_bucket_header_decode.sv
// Combinational slot select: picks the valid bit, PAddr and leaf of one slot
// out of a registered bucket header.
module stash_path_unpacker_bucket_header_decode
  import stash_path_unpacker_pkg::*;
#(
  parameter int ORAML     = ORAML_DEF,
  parameter int ORAMU     = ORAMU_DEF,
  parameter int ORAMZ     = ORAMZ_DEF,
  parameter int DataWidth = DATA_WIDTH_DEF,
  parameter int SW        = (ORAMZ > 1) ? $clog2(ORAMZ) : 1
) (
  input  logic [DataWidth-1:0] header_i,
  input  logic [SW-1:0]        slot_i,
  output logic                 valid_o,
  output logic [ORAMU-1:0]     paddr_o,
  output logic [ORAML-1:0]     leaf_o
);

  assign valid_o = header_i[slot_i];
  assign paddr_o = header_i[hdr_paddr_lsb(ORAMZ, ORAMU, int'(slot_i)) +: ORAMU];
  assign leaf_o  = header_i[hdr_leaf_lsb(ORAMZ, ORAMU, ORAML, int'(slot_i)) +: ORAML];

endmodule

// File: rtl/stash_path_unpacker.sv
// Splits a decrypted ORAM path stream into bucket headers and data blocks, forwarding
// only real blocks (with PAddr/leaf) to the stash and pulsing PathReadDone per path.
module stash_path_unpacker
  import stash_path_unpacker_pkg::*;
#(
  parameter int   ORAML     = ORAML_DEF,
  parameter int   ORAMU     = ORAMU_DEF,
  parameter int   ORAMZ     = ORAMZ_DEF,
  parameter int   DataWidth = DATA_WIDTH_DEF,
  parameter int   BlkChunks = BLK_CHUNKS_DEF,
  localparam int  CW        = $clog2(ORAMZ * (ORAML + 1)) + 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DataWidth-1:0] InData,
  input  logic                 InValid,
  output logic                 InReady,
  output logic [DataWidth-1:0] WriteData,
  output logic [ORAMU-1:0]     WritePAddr,
  output logic [ORAML-1:0]     WriteLeaf,
  output logic                 WriteInValid,
  input  logic                 WriteInReady,
  output logic                 PathReadDone,
  output logic [CW-1:0]        RealBlockCount
);

  localparam int CHW = (BlkChunks > 1) ? $clog2(BlkChunks) : 1;
  localparam int SW  = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;
  localparam int BKW = (ORAML > 0) ? $clog2(ORAML + 1) : 1;

  if (DataWidth < hdr_bits(ORAMZ, ORAMU, ORAML)) begin : g_header_too_wide
    $error("stash_path_unpacker: DataWidth cannot hold a bucket header");
  end

  unpack_state_e        state_q, state_d;
  logic [DataWidth-1:0] header_q, header_d;
  logic [CHW-1:0]       chunk_q, chunk_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [BKW-1:0]       bucket_q, bucket_d;
  logic [CW-1:0]        real_q, real_d;

  logic slot_valid;
  logic in_ready, write_valid, path_done;

  stash_path_unpacker_bucket_header_decode #(
    .ORAML    (ORAML),
    .ORAMU    (ORAMU),
    .ORAMZ    (ORAMZ),
    .DataWidth(DataWidth),
    .SW       (SW)
  ) u_header_decode (
    .header_i(header_q),
    .slot_i  (slot_q),
    .valid_o (slot_valid),
    .paddr_o (WritePAddr),
    .leaf_o  (WriteLeaf)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    header_d    = header_q;
    chunk_d     = chunk_q;
    slot_d      = slot_q;
    bucket_d    = bucket_q;
    real_d      = real_q;
    in_ready    = 1'b0;
    write_valid = 1'b0;
    path_done   = 1'b0;

    unique case (state_q)
      ST_HEADER: begin
        in_ready = 1'b1;
        if (InValid) begin
          header_d = InData;
          state_d  = ST_DATA;
          // The count is cleared only when a new path starts, so it stays readable after Done.
          if (bucket_q == '0) real_d = '0;
        end
      end

      ST_DATA: begin
        // Real slots stream straight through; dummy slots are swallowed at full rate.
        if (slot_valid) begin
          in_ready    = WriteInReady;
          write_valid = InValid;
        end else begin
          in_ready = 1'b1;
        end

        if (InValid && in_ready) begin
          if (chunk_q == CHW'(BlkChunks - 1)) begin
            chunk_d = '0;
            if (slot_valid) real_d = real_q + CW'(1);
            if (slot_q == SW'(ORAMZ - 1)) begin
              slot_d = '0;
              if (bucket_q == BKW'(ORAML)) begin
                bucket_d = '0;
                state_d  = ST_DONE;
              end else begin
                bucket_d = bucket_q + BKW'(1);
                state_d  = ST_HEADER;
              end
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end else begin
            chunk_d = chunk_q + CHW'(1);
          end
        end
      end

      ST_DONE: begin
        path_done = 1'b1;
        state_d   = ST_HEADER;
      end

      default: state_d = ST_HEADER;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_HEADER;
      header_q <= '0;
      chunk_q  <= '0;
      slot_q   <= '0;
      bucket_q <= '0;
      real_q   <= '0;
    end else begin
      state_q  <= state_d;
      header_q <= header_d;
      chunk_q  <= chunk_d;
      slot_q   <= slot_d;
      bucket_q <= bucket_d;
      real_q   <= real_d;
    end
  end

  assign InReady        = in_ready;
  assign WriteData      = InData;
  assign WriteInValid   = write_valid;
  assign PathReadDone   = path_done;
  assign RealBlockCount = real_q;

endmodule

// File: tb/tb_stash_path_unpacker.sv
// Self-checking bench for stash_path_unpacker: random paths, a block-level reference
// model of which chunks reach the stash, and a scoreboard of forwarded writes.
module tb_stash_path_unpacker;

  localparam int L  = 32;
  localparam int U  = 32;
  localparam int Z  = 4;
  localparam int DW = 512;
  localparam int BC = 2;
  localparam int CW = $clog2(Z * (L + 1)) + 1;
  localparam int PATH_CHUNKS = (L + 1) * (1 + Z * BC);

  localparam int K_HDR   = 0;
  localparam int K_REAL  = 1;
  localparam int K_DUMMY = 2;

  typedef struct {
    int            kind;
    logic [DW-1:0] data;
    bit            blk_last;
    int            bucket;
    int            idx;
  } item_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [U-1:0]  paddr;
    logic [L-1:0]  leaf;
  } wr_t;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [DW-1:0] InData = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [DW-1:0] WriteData;
  logic [U-1:0]  WritePAddr;
  logic [L-1:0]  WriteLeaf;
  logic          WriteInValid;
  logic          WriteInReady = 1'b1;
  logic          PathReadDone;
  logic [CW-1:0] RealBlockCount;

  int total = 0;
  int bad   = 0;
  int real_exp = 0;

  always #5 Clock = ~Clock;

  stash_path_unpacker #(
    .ORAML(L), .ORAMU(U), .ORAMZ(Z), .DataWidth(DW), .BlkChunks(BC)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .InData        (InData),
    .InValid       (InValid),
    .InReady       (InReady),
    .WriteData     (WriteData),
    .WritePAddr    (WritePAddr),
    .WriteLeaf     (WriteLeaf),
    .WriteInValid  (WriteInValid),
    .WriteInReady  (WriteInReady),
    .PathReadDone  (PathReadDone),
    .RealBlockCount(RealBlockCount)
  );

  function automatic logic [DW-1:0] rand_chunk();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one path (or part of one, when abort_bucket >= 0) and checks every cycle.
  task automatic run_path(input logic [Z-1:0] vfix, input bit vrand, input bit pseq,
                          input int rdy_pct, input int gap_pct, input int abort_bucket,
                          output int n_wr, output int n_acc, output int n_done);
    item_t         items[$];
    wr_t           exp_wr[$];
    item_t         it;
    wr_t           w;
    logic [DW-1:0] hdr;
    logic [Z-1:0]  vm;
    logic [U-1:0]  pa[Z];
    logic [L-1:0]  lf[Z];
    int            k, cyc, idx;
    bit            acc;

    n_wr = 0; n_acc = 0; n_done = 0;
    for (int b = 0; b <= L; b++) begin
      vm  = vrand ? Z'($urandom) : vfix;
      hdr = rand_chunk();
      for (int s = 0; s < Z; s++) begin
        pa[s] = pseq ? U'(s + 1) : U'($urandom);
        lf[s] = L'($urandom);
        hdr[s] = vm[s];
        hdr[Z + s*U +: U] = pa[s];
        hdr[Z + Z*U + s*L +: L] = lf[s];
      end
      items.push_back('{kind: K_HDR, data: hdr, blk_last: 1'b0, bucket: b, idx: 0});
      idx = 1;
      for (int s = 0; s < Z; s++) begin
        for (int c = 0; c < BC; c++) begin
          it = '{kind: vm[s] ? K_REAL : K_DUMMY, data: rand_chunk(),
                 blk_last: (c == BC - 1), bucket: b, idx: idx};
          items.push_back(it);
          idx++;
          if (vm[s]) exp_wr.push_back('{data: it.data, paddr: pa[s], leaf: lf[s]});
        end
      end
    end

    k = 0; cyc = 0;
    while (k < items.size()) begin
      it = items[k];
      InValid      = ($urandom_range(99) >= gap_pct);
      InData       = it.data;
      WriteInReady = ($urandom_range(99) < rdy_pct);
      @(negedge Clock);

      total++;
      if (PathReadDone !== 1'b0 || RealBlockCount !== CW'(real_exp)) begin
        bad++;
        $display("FAIL path_flags b=%0d i=%0d: done=%b count=%0d, want done=0 count=%0d",
                 it.bucket, it.idx, PathReadDone, RealBlockCount, real_exp);
      end
      total++;
      if (it.kind == K_REAL) begin
        if (InReady !== WriteInReady || WriteInValid !== InValid) begin
          bad++;
          $display("FAIL real_handshake b=%0d i=%0d: ready=%b wvalid=%b, want ready=%b wvalid=%b",
                   it.bucket, it.idx, InReady, WriteInValid, WriteInReady, InValid);
        end
      end else if (InReady !== 1'b1 || WriteInValid !== 1'b0) begin
        bad++;
        $display("FAIL idle_handshake b=%0d i=%0d kind=%0d: ready=%b wvalid=%b, want ready=1 wvalid=0",
                 it.bucket, it.idx, it.kind, InReady, WriteInValid);
      end

      if (WriteInValid === 1'b1 && WriteInReady === 1'b1) begin
        n_wr++;
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_extra: unexpected write paddr=%h, want no write", WritePAddr);
        end else begin
          w = exp_wr.pop_front();
          if (WriteData !== w.data || WritePAddr !== w.paddr || WriteLeaf !== w.leaf) begin
            bad++;
            $display("FAIL scoreboard_write #%0d: paddr=%h leaf=%h data[31:0]=%h, want paddr=%h leaf=%h data[31:0]=%h",
                     n_wr, WritePAddr, WriteLeaf, WriteData[31:0], w.paddr, w.leaf, w.data[31:0]);
          end
        end
      end

      acc = InValid && (it.kind != K_REAL || WriteInReady);
      if (acc) begin
        n_acc++;
        if (it.kind == K_HDR && it.bucket == 0) real_exp = 0;
        if (it.kind == K_REAL && it.blk_last) real_exp++;
      end

      if (it.bucket == abort_bucket && it.idx == 3) begin
        #2 Reset = 1'b1;
        #1;
        total++;
        if (WriteInValid !== 1'b0 || PathReadDone !== 1'b0 || RealBlockCount !== '0 ||
            WritePAddr !== '0 || WriteLeaf !== '0) begin
          bad++;
          $display("FAIL async_reset: wvalid=%b done=%b count=%0d paddr=%h leaf=%h, want all 0",
                   WriteInValid, PathReadDone, RealBlockCount, WritePAddr, WriteLeaf);
        end
        InValid = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b0;
        real_exp = 0;
        @(negedge Clock);
        total++;
        if (InReady !== 1'b1 || RealBlockCount !== '0 || PathReadDone !== 1'b0) begin
          bad++;
          $display("FAIL post_reset: ready=%b count=%0d done=%b, want ready=1 count=0 done=0",
                   InReady, RealBlockCount, PathReadDone);
        end
        @(posedge Clock);
        #1;
        return;
      end

      @(posedge Clock);
      #1;
      if (acc) k++;
      cyc++;
      if (cyc > 4000) begin
        bad++;
        $display("FAIL path_timeout: stuck at item %0d of %0d", k, items.size());
        InValid = 1'b0;
        return;
      end
    end

    // Done cycle: a pending chunk must not be taken while the pulse is high.
    InValid      = 1'b1;
    InData       = rand_chunk();
    WriteInReady = 1'b1;
    @(negedge Clock);
    total++;
    if (PathReadDone !== 1'b1 || InReady !== 1'b0 || WriteInValid !== 1'b0 ||
        RealBlockCount !== CW'(real_exp)) begin
      bad++;
      $display("FAIL done_cycle: done=%b ready=%b wvalid=%b count=%0d, want done=1 ready=0 wvalid=0 count=%0d",
               PathReadDone, InReady, WriteInValid, RealBlockCount, real_exp);
    end
    if (PathReadDone === 1'b1) n_done++;
    @(posedge Clock);
    #1 InValid = 1'b0;

    total++;
    if (exp_wr.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_missing: %0d writes never seen, want 0", exp_wr.size());
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; WriteInReady = 1'b1; InData = '0;
    repeat (3) @(posedge Clock);
    #1;
    total++;
    if (WriteInValid !== 1'b0 || PathReadDone !== 1'b0 || RealBlockCount !== '0 ||
        WritePAddr !== '0 || WriteLeaf !== '0) begin
      bad++;
      $display("FAIL reset_values: wvalid=%b done=%b count=%0d paddr=%h leaf=%h, want all 0",
               WriteInValid, PathReadDone, RealBlockCount, WritePAddr, WriteLeaf);
    end
    Reset = 1'b0;
    real_exp = 0;
    @(negedge Clock);
    total++;
    if (InReady !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: ready=%b, want 1", InReady);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_all_valid();
    int n_wr, n_acc, n_done;
    run_path(4'b1111, 1'b0, 1'b1, 100, 0, -1, n_wr, n_acc, n_done);
    total++;
    if (n_wr != 264 || n_done != 1 || n_acc != PATH_CHUNKS || RealBlockCount !== CW'(132)) begin
      bad++;
      $display("FAIL all_valid: writes=%0d done=%0d acc=%0d count=%0d, want 264 1 %0d 132",
               n_wr, n_done, n_acc, RealBlockCount, PATH_CHUNKS);
    end
  endtask

  task automatic test_sparse();
    int n_wr, n_acc, n_done;
    run_path(4'b0101, 1'b0, 1'b0, 100, 0, -1, n_wr, n_acc, n_done);
    total++;
    if (n_wr != 132 || n_done != 1 || n_acc != PATH_CHUNKS || RealBlockCount !== CW'(66)) begin
      bad++;
      $display("FAIL sparse: writes=%0d done=%0d acc=%0d count=%0d, want 132 1 %0d 66",
               n_wr, n_done, n_acc, RealBlockCount, PATH_CHUNKS);
    end
  endtask

  task automatic test_all_dummy();
    int n_wr, n_acc, n_done;
    run_path(4'b0000, 1'b0, 1'b0, 30, 0, -1, n_wr, n_acc, n_done);
    total++;
    if (n_wr != 0 || n_done != 1 || n_acc != 297 || RealBlockCount !== '0) begin
      bad++;
      $display("FAIL all_dummy: writes=%0d done=%0d acc=%0d count=%0d, want 0 1 297 0",
               n_wr, n_done, n_acc, RealBlockCount);
    end
  endtask

  task automatic test_backpressure();
    int n_wr, n_acc, n_done;
    run_path('0, 1'b1, 1'b0, 50, 25, -1, n_wr, n_acc, n_done);
    total++;
    if (n_wr != 2 * real_exp || n_done != 1 || n_acc != PATH_CHUNKS ||
        RealBlockCount !== CW'(real_exp)) begin
      bad++;
      $display("FAIL backpressure: writes=%0d done=%0d acc=%0d count=%0d, want %0d 1 %0d %0d",
               n_wr, n_done, n_acc, RealBlockCount, 2 * real_exp, PATH_CHUNKS, real_exp);
    end
  endtask

  task automatic test_reset_mid_path();
    int n_wr, n_acc, n_done;
    run_path(4'b1111, 1'b0, 1'b0, 70, 10, 5, n_wr, n_acc, n_done);
    total++;
    if (n_done != 0) begin
      bad++;
      $display("FAIL abort_done: done pulses=%0d, want 0", n_done);
    end
    run_path('0, 1'b1, 1'b0, 80, 10, -1, n_wr, n_acc, n_done);
    total++;
    if (n_done != 1 || n_acc != PATH_CHUNKS || RealBlockCount !== CW'(real_exp)) begin
      bad++;
      $display("FAIL after_abort: done=%0d acc=%0d count=%0d, want 1 %0d %0d",
               n_done, n_acc, RealBlockCount, PATH_CHUNKS, real_exp);
    end
  endtask

  task automatic test_back_to_back();
    int n_wr, n_acc, n_done, first_count;
    run_path('0, 1'b1, 1'b0, 90, 0, -1, n_wr, n_acc, n_done);
    first_count = real_exp;
    run_path('0, 1'b1, 1'b0, 90, 40, -1, n_wr, n_acc, n_done);
    total++;
    if (n_done != 1 || n_acc != PATH_CHUNKS || RealBlockCount !== CW'(real_exp)) begin
      bad++;
      $display("FAIL back_to_back: done=%0d acc=%0d count=%0d (first=%0d), want 1 %0d %0d",
               n_done, n_acc, RealBlockCount, first_count, PATH_CHUNKS, real_exp);
    end
    @(negedge Clock);
    total++;
    if (PathReadDone !== 1'b0 || InReady !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_path: done=%b ready=%b, want done=0 ready=1",
               PathReadDone, InReady);
    end
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_sparse();
    test_all_dummy();
    test_backpressure();
    test_reset_mid_path();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stash_path_unpacker.md
Name: stash_path_unpacker

Overview:
Sits directly upstream of the stash write interface (the backend path read port). It consumes the decrypted path stream from the AES decrypt stage, one bucket at a time: a header chunk, then ORAMZ blocks of BlkChunks data chunks each. It forwards only real blocks, with their PAddr and leaf, to the stash, and drops dummy blocks. When the last bucket of the path is consumed it pulses PathReadDone, which the ORAM controller uses to issue StartReadOperation.

Parameters:
ORAML, 32, leaf width; path length is ORAML+1 buckets
ORAMU, 32, program address width
ORAMZ, 4, blocks per bucket
DataWidth, 512, chunk width; must be >= ORAMZ*(1+ORAMU+ORAML) (checked by a static assertion)
BlkChunks, 2, chunks per block

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
InData  in  DataWidth  decrypted chunk (header or data)
InValid  in  1  InData valid
InReady  out  1  chunk accepted when InValid&InReady
WriteData  out  DataWidth  chunk to stash
WritePAddr  out  ORAMU  PAddr of current real block
WriteLeaf  out  ORAML  leaf of current real block
WriteInValid  out  1  chunk to stash valid
WriteInReady  in  1  stash accepts chunk
PathReadDone  out  1  one-cycle pulse after last bucket consumed
RealBlockCount  out  CW=clog2(ORAMZ*(ORAML+1))+1  real blocks forwarded on current/last path

Behaviour:
- Header layout, LSB first:
  - ORAMZ valid bits: slot i at bit i.
  - ORAMZ PAddrs: slot i at ORAMZ + i*ORAMU.
  - ORAMZ leaves: slot i at ORAMZ + ORAMZ*ORAMU + i*ORAML.
  - Remaining bits are ignored.
- FSM states: ST_Header, ST_Data, ST_Done. Reset enters ST_Header.
- Counters: ChunkCnt (0..BlkChunks-1), SlotCnt (0..ORAMZ-1), BucketCnt (0..ORAML). All reset to 0.
- ST_Header:
  - InReady=1, WriteInValid=0.
  - On InValid, register the header and go to ST_Data.
  - If BucketCnt==0, also clear RealBlockCount.
- ST_Data, current slot valid:
  - Pure pass-through, no registering: WriteData=InData, WriteInValid=InValid, InReady=WriteInReady.
  - WritePAddr/WriteLeaf come from the registered header slot SlotCnt.
- ST_Data, current slot dummy:
  - InReady=1, WriteInValid=0; chunks are discarded.
- Chunk accounting: each accepted chunk increments ChunkCnt.
- At ChunkCnt==BlkChunks-1 with an accepted chunk (block end):
  - ChunkCnt wraps to 0 and SlotCnt increments.
  - If the slot was valid, RealBlockCount increments.
- At block end with SlotCnt==ORAMZ-1 (bucket end):
  - SlotCnt wraps to 0.
  - If BucketCnt==ORAML: BucketCnt wraps to 0 and go to ST_Done. Otherwise BucketCnt increments and go to ST_Header.
- ST_Done:
  - PathReadDone=1 for exactly one cycle; InReady=0, WriteInValid=0.
  - Next state ST_Header.
- RealBlockCount holds its value from ST_Done until the first header of the next path is accepted.
- Latency: zero-cycle combinational path from InData to WriteData. One header cycle per bucket. One Done cycle per path.
- Reset values:
  - WriteInValid=0, PathReadDone=0, RealBlockCount=0.
  - Header register=0, so WritePAddr=WriteLeaf=0.
  - InReady=1 once reset deasserts.
- Boundary conditions:
  - All-zero valid header: consumes ORAMZ*BlkChunks chunks with no stash writes.
  - WriteInReady low mid-block: stall with no chunk loss; counters advance only on InValid&InReady.
  - Reset asserted mid-path: all counters and the FSM clear immediately; the partial path is abandoned and PathReadDone is not pulsed.
  - Header with valid bits above ORAMZ: ignored.

Decomposition:
- Shared constants include (ORAM header field offsets, FSM encodings) alongside the existing ORAM constants; used by the matching writeback packer.
- One natural sub-module: bucket_header_decode, a combinational slot-select of valid/PAddr/leaf from the registered header given SlotCnt.
- Counters reuse the existing Counter primitive.

Test Plan:
- Path with all headers valid=4'b1111, PAddr=slot+1, WriteInReady=1 -> 4*(ORAML+1)=132 blocks and 264 chunks forwarded in order; WritePAddr cycles 1..4; PathReadDone pulses once, one cycle after the last chunk; RealBlockCount=132.
- Header valid=4'b0101 on every bucket -> only slots 0 and 2 are forwarded; dummy chunks are accepted with WriteInValid=0; RealBlockCount=66.
- All-dummy path (valid=0) -> zero stash writes; InReady stays 1 through data; PathReadDone pulses after 33*(1+8) accepted chunks; RealBlockCount=0.
- WriteInReady toggled randomly on a real block -> InReady mirrors WriteInReady; no duplicated or dropped chunk (scoreboard compares data); InValid gaps are tolerated.
- Reset asserted mid-bucket 5 -> outputs return to reset values asynchronously; the following full path is processed correctly from BucketCnt=0 with no stray PathReadDone.
- Back-to-back paths -> RealBlockCount holds the old value until the first header of the new path, then clears; the second PathReadDone pulses correctly.
